// File: rtl/l2_request_scheduler_pkg.sv
// cache_types_pkg: shared line/address types and scheduler enums for the L1/L2 glue.
// Revision 1.0
`default_nettype none

package cache_types_pkg;

  localparam int DEF_LINE_W = 128;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_CNT_W  = 16;

  typedef logic [DEF_LINE_W-1:0] line_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } requester_t;

endpackage

`default_nettype wire

// File: rtl/l2_request_scheduler_rr_pick2.sv
// rr_pick2: two-way round-robin select; a tie goes to the requester that was not granted last.
// Revision 1.0
`default_nettype none

module rr_pick2
  import cache_types_pkg::*;
(
  input  logic [1:0] req,
  input  requester_t last_grant,
  output logic       grant_valid,
  output requester_t grant_id
);

  // req[0] is the I-cache, req[1] the D-cache
  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_INSTR;
    if (req == 2'b10) begin
      grant_id = REQ_DATA;
    end else if (req == 2'b11 && last_grant == REQ_INSTR) begin
      grant_id = REQ_DATA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_request_scheduler.sv
// l2_request_scheduler: shares one L2 port between I- and D-cache with registered round-robin arbitration.
// Revision 1.0
`default_nettype none

module l2_request_scheduler
  import cache_types_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              instr_read,
  input  logic              instr_write,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [LINE_W-1:0] instr_wdata,
  output logic [LINE_W-1:0] instr_rdata,
  output logic              instr_resp,

  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [LINE_W-1:0] data_wdata,
  output logic [LINE_W-1:0] data_rdata,
  output logic              data_resp,

  output logic              L2_read,
  output logic              L2_write,
  output logic [ADDR_W-1:0] L2_addr,
  output logic [LINE_W-1:0] L2_wdata,
  input  logic [LINE_W-1:0] L2_rdata,
  input  logic              L2_resp,

  output logic [CNT_W-1:0]  grant_cnt_instr,
  output logic [CNT_W-1:0]  grant_cnt_data
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]        state;
  requester_t        owner;
  requester_t        last_grant;
  logic [LINE_W-1:0] line;
  logic [CNT_W-1:0]  cnt_instr;
  logic [CNT_W-1:0]  cnt_data;

  logic              grant_valid;
  requester_t        grant_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req         ({data_read | data_write, instr_read | instr_write}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // A grant is only issued when read|write is high, so write-low implies a read.
  always_comb begin
    sel_write = instr_write;
    sel_addr  = instr_addr;
    sel_wdata = instr_wdata;
    if (grant_id == REQ_DATA) begin
      sel_write = data_write;
      sel_addr  = data_addr;
      sel_wdata = data_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= REQ_INSTR;
      last_grant <= REQ_DATA;
      L2_read    <= 1'b0;
      L2_write   <= 1'b0;
      L2_addr    <= '0;
      L2_wdata   <= '0;
      line       <= '0;
      instr_resp <= 1'b0;
      data_resp  <= 1'b0;
    end else begin
      instr_resp <= 1'b0;
      data_resp  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_BUSY;
            owner      <= grant_id;
            last_grant <= grant_id;
            L2_addr    <= sel_addr;
            L2_wdata   <= sel_wdata;
            L2_write   <= sel_write;
            L2_read    <= ~sel_write;
          end
        end
        ST_BUSY: begin
          if (L2_resp) begin
            state      <= ST_RESP;
            line       <= L2_rdata;
            L2_read    <= 1'b0;
            L2_write   <= 1'b0;
            instr_resp <= (owner == REQ_INSTR);
            data_resp  <= (owner == REQ_DATA);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_instr <= '0;
      cnt_data  <= '0;
    end else if (state == ST_IDLE && grant_valid) begin
      if (grant_id == REQ_INSTR) begin
        if (cnt_instr != {CNT_W{1'b1}}) cnt_instr <= cnt_instr + CNT_W'(1);
      end else begin
        if (cnt_data != {CNT_W{1'b1}}) cnt_data <= cnt_data + CNT_W'(1);
      end
    end
  end

  assign instr_rdata     = line;
  assign data_rdata      = line;
  assign grant_cnt_instr = cnt_instr;
  assign grant_cnt_data  = cnt_data;

endmodule

`default_nettype wire

// File: tb/tb_l2_request_scheduler.sv
// tb_l2_request_scheduler: directed stimulus with a response scoreboard for l2_request_scheduler.
// Revision 1.0
`default_nettype none

module tb_l2_request_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         instr_read = 1'b0, instr_write = 1'b0;
  logic [15:0]  instr_addr = '0;
  logic [127:0] instr_wdata = '0;
  logic [127:0] instr_rdata;
  logic         instr_resp;
  logic         data_read = 1'b0, data_write = 1'b0;
  logic [15:0]  data_addr = '0;
  logic [127:0] data_wdata = '0;
  logic [127:0] data_rdata;
  logic         data_resp;
  logic         L2_read, L2_write;
  logic [15:0]  L2_addr;
  logic [127:0] L2_wdata;
  logic [127:0] L2_rdata = '0;
  logic         L2_resp = 1'b0;
  logic [15:0]  grant_cnt_instr, grant_cnt_data;

  l2_request_scheduler dut (
    .clk(clk), .rst(rst),
    .instr_read(instr_read), .instr_write(instr_write), .instr_addr(instr_addr),
    .instr_wdata(instr_wdata), .instr_rdata(instr_rdata), .instr_resp(instr_resp),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_resp(data_resp),
    .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr), .L2_wdata(L2_wdata),
    .L2_rdata(L2_rdata), .L2_resp(L2_resp),
    .grant_cnt_instr(grant_cnt_instr), .grant_cnt_data(grant_cnt_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_data;
    logic [127:0] line;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   pushed = 0;
  int   resp_seen = 0;

  localparam logic [127:0] A5 = {16{8'hA5}};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && (instr_resp || data_resp)) begin
      resp_seen++;
      if (instr_resp && data_resp) begin
        chk("resp_both", {instr_resp, data_resp}, 2'b00);
      end else if (q.size() == 0) begin
        chk("resp_unexpected", {instr_resp, data_resp}, 2'b00);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_who", data_resp, e.is_data);
        chk("resp_line", data_resp ? data_rdata : instr_rdata, e.line);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    {instr_read, instr_write, data_read, data_write} = 4'b0;
    L2_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits for the L2 strobe, checks the latched command, answers after dly cycles,
  // then drops the finished request in the cycle after its resp.
  task automatic serve(input logic who_data, input logic wr, input logic [15:0] addr,
                       input logic [127:0] wd, input int dly, input logic [127:0] rd);
    int n = 0;
    while (!(L2_read || L2_write) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!(L2_read || L2_write)) begin
      chk("strobe_timeout", 1'b0, 1'b1);
      return;
    end
    chk("L2_write", L2_write, wr);
    chk("L2_read", L2_read, !wr);
    chk("L2_addr", L2_addr, addr);
    if (wr) chk("L2_wdata", L2_wdata, wd);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("hold_addr", L2_addr, addr);
      chk("hold_strobe", {L2_read, L2_write}, wr ? 2'b01 : 2'b10);
    end
    L2_rdata = rd;
    L2_resp  = 1'b1;
    q.push_back('{who_data, rd});
    pushed++;
    @(posedge clk); #1;
    L2_resp = 1'b0;
    chk("strobe_off", {L2_read, L2_write}, 2'b00);
    @(posedge clk); #1;
    if (who_data) {data_read, data_write} = 2'b00;
    else {instr_read, instr_write} = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_strobes", {L2_read, L2_write}, 2'b00);
    chk("rst_resps", {instr_resp, data_resp}, 2'b00);
    chk("rst_addr", L2_addr, 16'h0);
    chk("rst_wdata", L2_wdata, 128'h0);
    chk("rst_line", instr_rdata, 128'h0);
    chk("rst_cnts", {grant_cnt_instr, grant_cnt_data}, 32'h0);

    // single I-cache read
    instr_addr = 16'h0040; instr_read = 1'b1;
    serve(1'b0, 1'b0, 16'h0040, '0, 2, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    chk("cnt_instr_1", grant_cnt_instr, 16'd1);
    chk("cnt_data_0", grant_cnt_data, 16'd0);

    // conflicts from reset: I first, then D; repeat conflict goes to I again
    do_reset();
    instr_addr = 16'h0100; instr_read = 1'b1;
    data_addr = 16'h0200; data_wdata = A5; data_write = 1'b1;
    serve(1'b0, 1'b0, 16'h0100, '0, 1, 128'hABCD);
    serve(1'b1, 1'b1, 16'h0200, A5, 0, 128'h0);
    instr_addr = 16'h0110; instr_read = 1'b1;
    data_addr = 16'h0210; data_read = 1'b1; data_write = 1'b1;
    serve(1'b0, 1'b0, 16'h0110, '0, 0, 128'h5A5A);
    serve(1'b1, 1'b1, 16'h0210, A5, 1, 128'h0);
    chk("cnt_instr_2", grant_cnt_instr, 16'd2);
    chk("cnt_data_2", grant_cnt_data, 16'd2);

    // address change during BUSY is ignored
    data_addr = 16'h0300; data_read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_addr = 16'h0310;
    serve(1'b1, 1'b0, 16'h0300, '0, 3, 128'hFEED);

    // reset in the middle of a transaction
    data_addr = 16'h0400; data_read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_before_rst", L2_read, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {L2_read, L2_write}, 2'b00);
    chk("rst_mid_addr", L2_addr, 16'h0);
    chk("rst_mid_cnts", {grant_cnt_instr, grant_cnt_data}, 32'h0);
    {data_read, data_write} = 2'b00;
    @(posedge clk); #1 rst = 1'b0;
    instr_addr = 16'h0500; instr_read = 1'b1;
    data_addr = 16'h0600; data_read = 1'b1;
    serve(1'b0, 1'b0, 16'h0500, '0, 0, 128'h0500);
    serve(1'b1, 1'b0, 16'h0600, '0, 0, 128'h0600);

    // spurious L2_resp while idle
    begin
      int seen_before;
      seen_before = resp_seen;
      L2_rdata = 128'hDEAD; L2_resp = 1'b1;
      @(posedge clk); #1 L2_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("spur_resps", resp_seen, seen_before);
      chk("spur_cnts", {grant_cnt_instr, grant_cnt_data}, {16'd1, 16'd1});
      chk("spur_strobes", {L2_read, L2_write}, 2'b00);
    end
    data_addr = 16'h0700; data_read = 1'b1;
    @(posedge clk); #1;
    chk("latency_1", L2_read, 1'b1);
    serve(1'b1, 1'b0, 16'h0700, '0, 0, 128'h0700);

    // grant counter saturation
    do_reset();
    @(posedge clk); #1;
    force dut.cnt_data = 16'hFFFE;
    #2;
    release dut.cnt_data;
    #1;
    chk("cnt_preload", grant_cnt_data, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      data_addr = 16'h0800 + 16'(k); data_read = 1'b1;
      serve(1'b1, 1'b0, 16'h0800 + 16'(k), '0, 0, 128'(k));
      chk("cnt_sat", grant_cnt_data, 16'hFFFF);
    end
    chk("cnt_instr_sat_test", grant_cnt_instr, 16'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    chk("resp_count", resp_seen, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l2_request_scheduler.md
# l2_request_scheduler

Registered, round-robin scheduler that shares the single L2 cache port between the L1 instruction cache and L1 data cache. It sits between the two L1 miss/writeback interfaces and the L2 arb-side interface in the cache system. It latches one requester's command, address and write line, and holds them stable on the L2 port until `L2_resp`. It then returns the line with a one-cycle response pulse to the granted L1 only. Saturating grant counters are provided for performance monitoring.

## Interface
- `LINE_W`, 128: cache line width in bits (L1↔L2 transfer size).
- `ADDR_W`, 16: address width.
- `CNT_W`, 16: grant counter width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_read`, `instr_write`  in  1 each  I-cache L1 miss-side strobes.
- `instr_addr`  in  ADDR_W  I-cache line address.
- `instr_wdata`  in  LINE_W  I-cache writeback line (unused in practice).
- `instr_rdata`  out  LINE_W  returned line.
- `instr_resp`  out  1  one-cycle completion pulse to the I-cache.
- `data_read`, `data_write`, `data_addr`, `data_wdata`, `data_rdata`, `data_resp`: same shapes and meanings, for the D-cache.
- `L2_read`, `L2_write`  out  1 each  strobes to L2.
- `L2_addr`  out  ADDR_W  registered address.
- `L2_wdata`  out  LINE_W  registered write line.
- `L2_rdata`  in  LINE_W  L2 read line.
- `L2_resp`  in  1  L2 completion.
- `grant_cnt_instr`, `grant_cnt_data`  out  CNT_W  saturating count of grants issued per requester.

## Operation
- States: `IDLE`, `BUSY`, `RESP`. Register `owner` ∈ {INSTR, DATA}. Register `last_grant` resets to DATA, so the I-cache wins the first conflict.
- IDLE:
  - If exactly one requester has `read|write` high, grant it.
  - If both are high, grant the one ≠ `last_grant`.
  - On a grant: latch addr, wdata and command; set `owner` and `last_grant`; increment that requester's counter, saturating at all-ones; go to BUSY.
- Command latch: if a requester asserts `read` and `write` together, write is serviced (`L2_write=1`, `L2_read=0`). Exactly one L2 strobe is ever high.
- BUSY:
  - `L2_read`/`L2_write`, `L2_addr` and `L2_wdata` are driven from the latches and held constant. Changes on requester inputs are ignored.
  - On `L2_resp`: capture `L2_rdata` into the line register and go to RESP.
- RESP:
  - Assert `owner`'s resp for exactly one cycle. The other requester's resp stays 0.
  - L2 strobes are low.
  - Next state is IDLE.
- `instr_rdata` and `data_rdata` are both driven from the line register. They are valid only while the matching resp is high.
- `L2_resp` in IDLE or RESP is ignored.
- Requester contract: hold request and operands stable until its resp; drop the request in the cycle after resp. The IDLE cycle after RESP therefore never re-grants a finished request.
- The non-granted requester waits with its request held. It is guaranteed the next grant (strict alternation under contention).

## Timing
- Reset (async, immediate) values:
  - state IDLE; `last_grant` DATA.
  - all strobes and resps 0.
  - `L2_addr`, `L2_wdata`, line register, counters 0.
- Reset mid-BUSY drops the L2 strobes immediately. The in-flight L2 transaction is abandoned.
- Latency:
  - Request seen in IDLE at cycle 0 → L2 strobe at cycle 1.
  - `L2_resp` at cycle k → requester resp at cycle k+1.
  - Minimum 3 cycles request→resp (`L2_resp` same cycle as strobe at cycle 1).
- Back-to-back: after RESP, one IDLE cycle precedes the next grant. Minimum per-transaction occupancy is 3 cycles.
- All outputs are registered; no combinational input→output path.

## Structure
- `cache_types_pkg` holds:
  - `line_t` (LINE_W), `addr_t` (ADDR_W);
  - enum `sched_state_t` {IDLE, BUSY, RESP};
  - enum `requester_t` {REQ_INSTR, REQ_DATA}.
- Sub-module `rr_pick2`: combinational 2-way round-robin select. Inputs: `req[1:0]`, `last_grant`. Outputs: `grant_valid`, `grant_id`. The FSM, latches and counters stay in the top.

## Test plan
- I-cache read only, `instr_addr`=16'h0040, `L2_resp` 2 cycles after strobe → `L2_read`=1 with `L2_addr`=16'h0040; `instr_resp` pulses once with `instr_rdata`=`L2_rdata`; `data_resp` stays 0; `grant_cnt_instr`=1.
- Both request from reset (I read 16'h0100, D write 16'h0200 with `wdata`=128'hA5…A5) → I granted first, then D. `L2_write`=1 with `L2_addr`=16'h0200 and `L2_wdata`=128'hA5…A5. Then a repeat conflict → I again.
- Requester changes `data_addr` 16'h0300→16'h0310 during BUSY → `L2_addr` stays 16'h0300 until `L2_resp`.
- `rst` asserted mid-BUSY → `L2_read`/`L2_write` fall before the next edge; all outputs 0; the first conflict after reset grants I.
- Spurious `L2_resp` in IDLE → no resp to either requester; state and counters unchanged.
- Preload `grant_cnt_data` to 16'hFFFE (via forced grants) and issue 3 D grants → counter holds at 16'hFFFF.
